move_tick_gen: RTL
==================

MOVE_TICK_GEN -- requirements
Module: move_tick_gen

Interface
REQ-001 Parameter N_BUTTONS, default 3: number of call-button inputs.
REQ-002 Parameter CNT_W, default 26: period counter width in bits.
REQ-003 Parameter MOVE_TIME, default 10: terminal count in move mode; SHALL satisfy 1 <= MOVE_TIME < 2^CNT_W.
REQ-004 Parameter DOOR_TIME, default 20: terminal count in door mode; SHALL satisfy 1 <= DOOR_TIME < 2^CNT_W.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 buttons  input  N_BUTTONS  call buttons, active-low; a press is a 1->0 transition.
REQ-008 moving  input  1  high while the car is travelling.
REQ-009 door_mode  input  1  selects terminal count: 0 = MOVE_TIME, 1 = DOOR_TIME.
REQ-010 move_clk  output  1  registered square wave, toggled at each terminal count.
REQ-011 tick  output  1  registered one-cycle pulse at each terminal count.
REQ-012 btn_event  output  N_BUTTONS  registered one-cycle pulse per detected press, one bit per button.
REQ-013 phase  output  CNT_W  current counter value.

Function
REQ-014 P SHALL be MOVE_TIME when door_mode=0 and DOOR_TIME when door_mode=1, sampled every cycle.
REQ-015 FSM states SHALL be INIT and RUN; reset enters INIT; INIT lasts exactly L cycles, then RUN is held until the next reset.
REQ-016 L SHALL be 3 with MOVE_SYNC_EN defined and 1 without it.
REQ-017 In INIT: counter=0, tick=0, move_clk=0, btn_event=0, and the edge-detect history register SHALL load the conditioned buttons each cycle.
REQ-018 In RUN, btn_event[i] SHALL be 1 for exactly one cycle when history[i]=1 and conditioned buttons[i]=0; history SHALL load the conditioned buttons every cycle.
REQ-019 Detection latency SHALL be 1 cycle from the edge of clk that samples the low level without MOVE_SYNC_EN, and 3 cycles with it.
REQ-020 A button held low through reset and INIT SHALL produce no btn_event.
REQ-021 In RUN with no restart: if counter < P, then counter increments and tick=0; otherwise counter=0, tick=1 and move_clk inverts.
REQ-022 tick period and move_clk half-period SHALL each be P+1 cycles.
REQ-023 Restart: if any btn_event bit would assert this cycle and moving=0, then counter=0, tick=0 and move_clk=0 on the same edge.
REQ-024 Restart SHALL take priority over a coincident terminal count.
REQ-025 When moving=1, button events SHALL still pulse btn_event but SHALL NOT disturb counter, tick or move_clk.
REQ-026 If door_mode changes while counter >= new P, the next cycle SHALL be a terminal count; the counter SHALL never exceed max(MOVE_TIME, DOOR_TIME).
REQ-027 Simultaneous presses on several buttons SHALL assert all corresponding btn_event bits in the same cycle.
REQ-028 The counter SHALL never wrap through 2^CNT_W.

Reset
REQ-029 While rst_n=0, regardless of clk: counter=0, tick=0, move_clk=0, btn_event=0, history=all ones, synchronizer flops=all ones, state=INIT.
REQ-030 rst_n asserted mid-period SHALL clear all state immediately; after release, behaviour SHALL be identical to power-up.

Configuration
REQ-031 Macro MOVE_SYNC_EN defined: each button passes through a 2-flop synchronizer (reset to 1) before edge detection; L=3.
REQ-032 Macro MOVE_SYNC_EN undefined: buttons feed edge detection directly; L=1; all other behaviour is unchanged.

Verification
REQ-033 Defaults, no sync, moving=0, door_mode=0, buttons idle high: tick first asserts at cycle L+11 after reset release, then every 11 cycles; move_clk toggles on each tick.
REQ-034 door_mode switched 0->1 while phase=5: the next tick occurs when phase reaches 20; switched 1->0 at phase=15: tick on the next cycle.
REQ-035 buttons[1] pulled low at phase=7, moving=0: btn_event=3'b010 for one cycle; on that edge phase=0 and move_clk=0; the next tick arrives 11 cycles later.
REQ-036 Same press with moving=1: btn_event pulses, and phase and move_clk continue undisturbed.
REQ-037 buttons=3'b000 held through reset: no btn_event. Later release and re-press of all three: btn_event=3'b111 for one cycle.
REQ-038 Press coincident with phase=10, moving=0: tick=0, phase=0, move_clk=0. Repeat with MOVE_SYNC_EN: latency is 3 cycles.

Source files
------------

// File: rtl/move_tick_gen.sv
// Move/door period tick generator with active-low call-button press detection.
// Optional MOVE_SYNC_EN adds a 2-flop synchronizer per button and stretches INIT to 3 cycles.
module move_tick_gen #(
  parameter int N_BUTTONS = 3,
  parameter int CNT_W     = 26,
  parameter int MOVE_TIME = 10,
  parameter int DOOR_TIME = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] buttons,
  input  logic                 moving,
  input  logic                 door_mode,
  output logic                 move_clk,
  output logic                 tick,
  output logic [N_BUTTONS-1:0] btn_event,
  output logic [CNT_W-1:0]     phase
);

  // state | meaning
  // INIT  | counter/outputs held clear, history primed with conditioned buttons
  // RUN   | period counting, press detection and restart
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef MOVE_SYNC_EN
  localparam int INIT_LEN = 3;
`else
  localparam int INIT_LEN = 1;
`endif

  localparam logic [1:0]       INIT_LAST = 2'(INIT_LEN - 1);
  localparam logic [CNT_W-1:0] MOVE_TC   = CNT_W'(MOVE_TIME);
  localparam logic [CNT_W-1:0] DOOR_TC   = CNT_W'(DOOR_TIME);

  logic [0:0]           state;
  logic [1:0]           init_cnt;
  logic [CNT_W-1:0]     counter;
  logic [N_BUTTONS-1:0] history;
  logic [N_BUTTONS-1:0] btn_cond;
  logic [N_BUTTONS-1:0] press;
  logic [CNT_W-1:0]     period_tc;
  logic                 restart;
  logic                 term;

`ifdef MOVE_SYNC_EN
  logic [N_BUTTONS-1:0] sync_q1;
  logic [N_BUTTONS-1:0] sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= buttons;
      sync_q2 <= sync_q1;
    end
  end

  assign btn_cond = sync_q2;
`else
  assign btn_cond = buttons;
`endif

  always_comb begin
    period_tc = door_mode ? DOOR_TC : MOVE_TC;
    press     = history & ~btn_cond;
    // a press while stationary restarts the period and wins over terminal count
    restart   = (state == ST_RUN) && (|press) && !moving;
    term      = (counter >= period_tc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= INIT_LAST;
    end else if (state == ST_INIT) begin
      if (init_cnt == 2'd0) begin
        state <= ST_RUN;
      end else begin
        init_cnt <= init_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history <= '1;
    end else begin
      history <= btn_cond;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_event <= '0;
    end else if (state == ST_RUN) begin
      btn_event <= press;
    end else begin
      btn_event <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= '0;
      tick     <= 1'b0;
      move_clk <= 1'b0;
    end else if (state == ST_INIT || restart) begin
      counter  <= '0;
      tick     <= 1'b0;
      move_clk <= 1'b0;
    end else if (term) begin
      counter  <= '0;
      tick     <= 1'b1;
      move_clk <= ~move_clk;
    end else begin
      counter  <= counter + 1'b1;
      tick     <= 1'b0;
    end
  end

  assign phase = counter;

endmodule
